// File: rtl/tanhshrink_lut_stream.sv
// Streaming tanhshrink: signed fixed-point lanes -> sign/magnitude Q4.4 LUT index -> signed rescaled result.
// Two register-slice stages, latency 2, one beat of PAR lanes per handshake.

module tanhshrink_lut_lane #(
   parameter int WI = 16,
   parameter int FI = 8,
   parameter int WO = 16,
   parameter int FO = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_s1_en,
   input  logic          i_s2_en,
   input  logic [WI-1:0] i_x,
   output logic [WO-1:0] o_y
);
   localparam int IN_SR  = (FI >= 4) ? FI - 4 : 0;
   localparam int IN_SL  = (FI >= 4) ? 0 : 4 - FI;
   localparam int OUT_SL = (FO >= 4) ? FO - 4 : 0;
   localparam int OUT_SR = (FO >= 4) ? 0 : 4 - FO;
   localparam int IW     = WI + 4;
   localparam int VW     = ((WO > 8 + OUT_SL) ? WO : 8 + OUT_SL) + 2;

   localparam logic [WI-1:0]        IN_MIN  = {1'b1, {(WI-1){1'b0}}};
   localparam logic [WI-1:0]        IN_MAX  = {1'b0, {(WI-1){1'b1}}};
   localparam logic signed [VW-1:0] OUT_MAX = $signed({{(VW-WO+1){1'b0}}, {(WO-1){1'b1}}});
   localparam logic signed [VW-1:0] OUT_MIN = $signed({{(VW-WO+1){1'b1}}, {(WO-1){1'b0}}});

   // floor(16*(x - tanh x)) at x = k/16; above k=27 tanh exceeds 15/16 so the result is k-16
   function automatic logic [7:0] f_lut(input logic [7:0] k);
      logic [7:0] l;
      case (k) inside
         [8'd0:8'd9]   : l = 8'd0;
         [8'd10:8'd12] : l = 8'd1;
         [8'd13:8'd14] : l = 8'd2;
         [8'd15:8'd16] : l = 8'd3;
         8'd17         : l = 8'd4;
         [8'd18:8'd19] : l = 8'd5;
         8'd20         : l = 8'd6;
         [8'd21:8'd22] : l = 8'd7;
         8'd23         : l = 8'd8;
         8'd24         : l = 8'd9;
         8'd25         : l = 8'd10;
         8'd26         : l = 8'd11;
         8'd27         : l = 8'd12;
         default       : l = k - 8'd16;
      endcase
      return l;
   endfunction

   logic                 w_sign;
   logic [WI-1:0]        w_mag;
   logic [IW-1:0]        w_idx_w;
   logic [7:0]           w_idx;
   logic                 r_sign;
   logic [7:0]           r_idx;
   logic [7:0]           w_l;
   logic [VW-1:0]        w_v;
   logic signed [VW-1:0] w_y;
   logic [WO-1:0]        w_ysat;
   logic [WO-1:0]        r_y;

   assign w_sign = i_x[WI-1];

   always_comb begin
      w_mag = i_x;
      if (w_sign) w_mag = (i_x == IN_MIN) ? IN_MAX : -i_x;
   end

   assign w_idx_w = ({{4{1'b0}}, w_mag} >> IN_SR) << IN_SL;
   assign w_idx   = (w_idx_w > IW'(255)) ? 8'hFF : w_idx_w[7:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sign <= 1'b0;
         r_idx  <= '0;
      end else if (i_s1_en) begin
         r_sign <= w_sign;
         r_idx  <= w_idx;
      end
   end

   assign w_l    = f_lut(r_idx);
   assign w_v    = ({{(VW-8){1'b0}}, w_l} >> OUT_SR) << OUT_SL;
   assign w_y    = r_sign ? -$signed(w_v) : $signed(w_v);
   assign w_ysat = (w_y > OUT_MAX) ? OUT_MAX[WO-1:0] :
                   (w_y < OUT_MIN) ? OUT_MIN[WO-1:0] : w_y[WO-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_y <= '0;
      else if (i_s2_en) r_y <= w_ysat;
   end

   assign o_y = r_y;
endmodule

module tanhshrink_lut_stream #(
   parameter int DATA_IN_0_PRECISION_0       = 16,
   parameter int DATA_IN_0_PRECISION_1       = 8,
   parameter int DATA_OUT_0_PRECISION_0      = 16,
   parameter int DATA_OUT_0_PRECISION_1      = 8,
   parameter int DATA_IN_0_PARALLELISM_DIM_0 = 4
) (
   input  logic                                                       clk,
   input  logic                                                       rst_n,
   input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PRECISION_0-1:0]  data_in_0,
   input  logic                                                       data_in_0_valid,
   output logic                                                       data_in_0_ready,
   output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
   output logic                                                       data_out_0_valid,
   input  logic                                                       data_out_0_ready
);
   localparam int PAR = DATA_IN_0_PARALLELISM_DIM_0;
   localparam int WI  = DATA_IN_0_PRECISION_0;
   localparam int WO  = DATA_OUT_0_PRECISION_0;

   logic [2:1] r_vld_pipe;
   logic       w_s1_en;
   logic       w_s2_en;

   // ready depends only on downstream ready and local valids, never on data_in_0_valid
   assign w_s2_en         = !r_vld_pipe[2] || data_out_0_ready;
   assign w_s1_en         = !r_vld_pipe[1] || w_s2_en;
   assign data_in_0_ready = w_s1_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_pipe <= '0;
      end else begin
         if (w_s1_en) r_vld_pipe[1] <= data_in_0_valid;
         if (w_s2_en) r_vld_pipe[2] <= r_vld_pipe[1];
      end
   end

   assign data_out_0_valid = r_vld_pipe[2];

   for (genvar g = 0; g < PAR; g++) begin : g_lane
      tanhshrink_lut_lane #(
         .WI (WI),
         .FI (DATA_IN_0_PRECISION_1),
         .WO (WO),
         .FO (DATA_OUT_0_PRECISION_1)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_s1_en (w_s1_en),
         .i_s2_en (w_s2_en),
         .i_x     (data_in_0[g*WI +: WI]),
         .o_y     (data_out_0[g*WO +: WO])
      );
   end
endmodule

// File: tb/tb_tanhshrink_lut_stream.sv
// Self-checking bench: real-arithmetic tanhshrink model feeding an in-order scoreboard,
// plus directed latency, saturation, backpressure, throughput, random handshake and reset cases.
module tb_tanhshrink_lut_stream;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] din;
   logic        in_valid, in_ready;
   logic [63:0] dout;
   logic        out_valid, out_ready;

   int n_tests = 0, n_fail = 0, n_in = 0, n_out = 0, cyc = 0;
   logic [63:0] exp_q[$];
   logic        prev_hold = 1'b0;
   logic [63:0] prev_data = '0;
   bit          tog_done = 1'b0;

   localparam logic [63:0] T1_IN  = {16'h0000, 16'h0009, 16'hFF00, 16'h0100};
   localparam logic [63:0] T1_OUT = {16'h0000, 16'h0000, 16'hFFD0, 16'h0030};
   localparam logic [63:0] T2_IN  = {16'hF000, 16'h1000, 16'h8000, 16'h7FFF};
   localparam logic [63:0] T2_OUT = {16'hF110, 16'h0EF0, 16'hF110, 16'h0EF0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   tanhshrink_lut_stream dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .data_in_0        (din),
      .data_in_0_valid  (in_valid),
      .data_in_0_ready  (in_ready),
      .data_out_0       (dout),
      .data_out_0_valid (out_valid),
      .data_out_0_ready (out_ready)
   );

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Q8.8 in -> Q4.4 magnitude index -> floor(16*(x - tanh x)) -> Q8.8 out
   function automatic logic [15:0] m_lane(input logic [15:0] x);
      int  xi, mag, k, l, y;
      real r;
      xi  = int'($signed(x));
      mag = (xi < 0) ? -xi : xi;
      if (mag > 32767) mag = 32767;
      k = mag / 16;
      if (k > 255) k = 255;
      r = k / 16.0;
      l = int'($floor(16.0 * (r - $tanh(r))));
      y = l * 16;
      if (xi < 0) y = -y;
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
      return y[15:0];
   endfunction

   function automatic logic [63:0] m_vec(input logic [63:0] d);
      logic [63:0] v;
      for (int i = 0; i < 4; i++) v[i*16 +: 16] = m_lane(d[i*16 +: 16]);
      return v;
   endfunction

   function automatic logic [63:0] rand_vec();
      logic [63:0] v;
      logic [15:0] w;
      for (int i = 0; i < 4; i++) begin
         case ($urandom_range(0, 3))
            0:       w = 16'($urandom);
            1:       w = 16'($urandom_range(0, 1023));
            2:       w = 16'(-$urandom_range(0, 1023));
            default: w = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
         endcase
         v[i*16 +: 16] = w;
      end
      return v;
   endfunction

   // compare process: accept/emit decisions made away from the clock edge
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) chk("hold_stable", {7'd0, out_valid, dout}, {7'd0, 1'b1, prev_data});
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_out: got %h expected no beat", dout);
            end else begin
               chk("scoreboard", {8'd0, dout}, {8'd0, exp_q.pop_front()});
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_data = dout;
         if (in_valid && in_ready) begin
            exp_q.push_back(m_vec(din));
            n_in++;
         end
      end
   end

   task automatic send_beat(input logic [63:0] d, input int maxcyc);
      bit ok;
      ok       = 1'b0;
      din      = d;
      in_valid = 1'b1;
      for (int i = 0; i < maxcyc && !ok; i++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: got no accept in %0d cycles expected accept", maxcyc);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int b_in, b_out, c0;
      rst_n = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b0;
      #12;
      chk("rst_out_valid", {71'd0, out_valid}, 72'd0);
      chk("rst_dout", {8'd0, dout}, 72'd0);
      chk("model_t1", {8'd0, m_vec(T1_IN)}, {8'd0, T1_OUT});
      chk("model_t2", {8'd0, m_vec(T2_IN)}, {8'd0, T2_OUT});
      chk("model_k24", {56'd0, m_lane(16'hFE80)}, {56'd0, 16'hFF70});
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", {71'd0, in_ready}, 72'd1);

      // 1: basic values and exact 2-cycle latency
      @(posedge clk); #1 out_ready = 1'b1;
      send_beat(T1_IN, 5);
      @(negedge clk); chk("lat_c1_valid", {71'd0, out_valid}, 72'd0);
      @(negedge clk); chk("lat_c2_valid", {71'd0, out_valid}, 72'd1);
      chk("t1_dout", {8'd0, dout}, {8'd0, T1_OUT});

      // 2: saturation
      @(posedge clk); #1;
      send_beat(T2_IN, 5);
      @(negedge clk);
      @(negedge clk); chk("t2_dout", {8'd0, dout}, {8'd0, T2_OUT});

      // 3: backpressure, capacity 2
      @(posedge clk); #1 out_ready = 1'b0;
      b_in = n_in; b_out = n_out;
      send_beat({16'h0200, 16'hFD00, 16'h0180, 16'hFFE0}, 5);
      send_beat({16'h0400, 16'hF800, 16'h00C0, 16'h0F00}, 5);
      din = {16'h0300, 16'hFE40, 16'h0010, 16'h8001}; in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready_low", {71'd0, in_ready}, 72'd0);
      end
      chk("bp_accepted", 72'(n_in - b_in), 72'd2);
      chk("bp_out_valid", {71'd0, out_valid}, 72'd1);
      @(posedge clk); #1 out_ready = 1'b1;
      send_beat({16'h0300, 16'hFE40, 16'h0010, 16'h8001}, 5);
      send_beat({16'h0E00, 16'hF300, 16'h01C0, 16'h0050}, 5);
      repeat (4) @(negedge clk);
      chk("bp_all_out", 72'(n_out - b_out), 72'd4);

      // 4: full throughput
      @(posedge clk); #1;
      b_out = n_out; c0 = cyc;
      for (int i = 0; i < 64; i++) send_beat(rand_vec(), 2);
      chk("thru_cycles", 72'(cyc - c0), 72'd64);
      repeat (3) @(negedge clk);
      chk("thru_out", 72'(n_out - b_out), 72'd64);

      // 5: random valid/ready
      fork
         begin
            while (!tog_done) begin
               @(posedge clk); #1;
               if (!tog_done) out_ready = ($urandom_range(0, 1) == 1);
            end
         end
      join_none
      b_in = n_in; b_out = n_out;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
         send_beat(rand_vec(), 200);
      end
      tog_done = 1'b1;
      @(posedge clk); #1 out_ready = 1'b1;
      repeat (5) @(negedge clk);
      chk("rand_in", 72'(n_in - b_in), 72'd1000);
      chk("rand_out", 72'(n_out - b_out), 72'd1000);
      chk("rand_q_empty", 72'(exp_q.size()), 72'd0);

      // 6: async reset with beats in flight
      @(posedge clk); #1 out_ready = 1'b0;
      send_beat({16'h0100, 16'h0200, 16'h0300, 16'h0400}, 5);
      send_beat({16'hFF00, 16'hFE00, 16'hFD00, 16'hFC00}, 5);
      @(negedge clk);
      chk("pre_rst_valid", {71'd0, out_valid}, 72'd1);
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", {71'd0, out_valid}, 72'd0);
      chk("rst_mid_dout", {8'd0, dout}, 72'd0);
      @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
      b_out = n_out;
      repeat (5) @(negedge clk);
      chk("no_stale_out", 72'(n_out - b_out), 72'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
